// File: rtl/warp_issue_scheduler_if.sv
// Issue-side handshake between the warp scheduler and the decode/issue stage.
// The scheduler drives the master side; the issue stage drives issue_ready.
interface warp_issue_scheduler_if #(
    parameter int NUM_WARPS = 16
);
    localparam int WID = $clog2(NUM_WARPS);

    logic                 issue_valid;
    logic                 issue_ready;
    logic [WID-1:0]       issue_warp;
    logic [NUM_WARPS-1:0] issue_warp_oh;

    modport master (
        output issue_valid,
        output issue_warp,
        output issue_warp_oh,
        input  issue_ready
    );

    modport slave (
        input  issue_valid,
        input  issue_warp,
        input  issue_warp_oh,
        output issue_ready
    );
endinterface

// File: rtl/warp_issue_scheduler.sv
// Round-robin warp issue scheduler with a per-warp cooldown after each accepted
// issue. The grant is registered and stays frozen while the issue stage stalls.
module warp_issue_scheduler #(
    parameter int NUM_WARPS = 16,
    parameter int COOLDOWN  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_WARPS-1:0]  req,
    input  logic                  flush,
    warp_issue_scheduler_if.master issue,
    output logic [NUM_WARPS-1:0]  blocked,
    output logic                  empty
);
    localparam int WID = $clog2(NUM_WARPS);
    localparam logic [NUM_WARPS-1:0] ONE_HOT_0 = NUM_WARPS'(1);

    logic                 r_valid;
    logic [WID-1:0]       r_warp;
    logic [NUM_WARPS-1:0] r_oh;
    logic [WID-1:0]       r_ptr;

    logic                 w_accept;
    logic [NUM_WARPS-1:0] w_elig;
    logic                 w_found;
    logic [WID-1:0]       w_sel;

    assign w_accept = r_valid & issue.issue_ready & ~flush;

    // A warp is eligible if it requests, is not cooling down, and is not the one
    // leaving this very cycle (its cooldown only becomes visible next cycle).
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_elig = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            w_elig[i] = req[i] & ~blocked[i] & ~(w_accept & (r_warp == WID'(i)));
        end
    end

    // Circular first-eligible scan starting at ptr; wrap is done by subtraction so
    // non-power-of-two warp counts never index past the end.
    always_comb begin
        int idx;
        w_found = 1'b0;
        w_sel   = '0;
        idx     = 0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NUM_WARPS) begin
                idx = idx - NUM_WARPS;
            end
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_sel   = WID'(idx);
            end
        end
    end

    // Grant register and round-robin pointer: flush beats stall beats load.
    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            r_valid <= 1'b0;
            r_warp  <= '0;
            r_oh    <= '0;
            r_ptr   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_oh    <= '0;
        end else if (r_valid && !issue.issue_ready) begin
            r_valid <= r_valid;
        end else begin
            if (w_accept) begin
                r_ptr <= (r_warp == WID'(NUM_WARPS - 1)) ? '0 : r_warp + WID'(1);
            end
            if (w_found) begin
                r_valid <= 1'b1;
                r_warp  <= w_sel;
                r_oh    <= ONE_HOT_0 << w_sel;
            end else begin
                r_valid <= 1'b0;
                r_oh    <= '0;
            end
        end
    end

    generate
        if (COOLDOWN > 0) begin : g_cooldown
            localparam int CW = $clog2(COOLDOWN + 1);
            logic [CW-1:0] r_cnt [NUM_WARPS];

            // Per-warp cooldown: load on accept, count down to zero, cleared by flush.
            always_ff @(posedge clk or negedge reset) begin
                // NOTE: this array is a handful of flops, not a RAM, so resetting every entry is intended.
                if (!reset) begin
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else if (flush) begin
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        r_cnt[i] <= '0;
                    end
                end else begin
                    for (int i = 0; i < NUM_WARPS; i++) begin
                        if (w_accept && (r_warp == WID'(i))) begin
                            r_cnt[i] <= CW'(COOLDOWN);
                        end else if (r_cnt[i] != '0) begin
                            r_cnt[i] <= r_cnt[i] - CW'(1);
                        end
                    end
                end
            end

            for (genvar g = 0; g < NUM_WARPS; g++) begin : g_blk
                assign blocked[g] = (r_cnt[g] != '0);
            end
        end else begin : g_no_cooldown
            assign blocked = '0;
        end
    endgenerate

    assign issue.issue_valid   = r_valid;
    assign issue.issue_warp    = r_warp;
    assign issue.issue_warp_oh = r_oh;
    assign empty               = ~r_valid & ~|(req & ~blocked);
endmodule

// File: tb/tb_warp_issue_scheduler.sv
// Bench for warp_issue_scheduler: two instances (COOLDOWN=4 and COOLDOWN=0)
// share one stimulus stream; a time-based reference model predicts each cycle,
// and a separate monitor compares the DUT outputs against the queued predictions.
module tb_warp_issue_scheduler;
    localparam int NW = 16;

    typedef struct packed {
        logic        valid;
        logic [3:0]  warp;
        logic [15:0] oh;
        logic [15:0] blocked;
        logic        empty;
    } stat_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic        flush;
    logic        ready;

    logic [15:0] blk0, blk1;
    logic        emp0, emp1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    warp_issue_scheduler_if #(.NUM_WARPS(NW)) if0 ();
    warp_issue_scheduler_if #(.NUM_WARPS(NW)) if1 ();
    assign if0.issue_ready = ready;
    assign if1.issue_ready = ready;

    warp_issue_scheduler #(.NUM_WARPS(NW), .COOLDOWN(4)) dut0 (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .issue(if0.master), .blocked(blk0), .empty(emp0)
    );

    warp_issue_scheduler #(.NUM_WARPS(NW), .COOLDOWN(0)) dut1 (
        .clk(clk), .reset(reset), .req(req), .flush(flush),
        .issue(if1.master), .blocked(blk1), .empty(emp1)
    );

    // Scoreboard queues, filled by the stimulus side and drained by the monitor.
    stat_t exp_stat [2][$];
    int    exp_xfer [2][$];

    // Reference model: a warp accepted in cycle t is blocked in cycles t+1..t+cd.
    int   cd [2] = '{4, 0};
    logic m_valid [2];
    int   m_warp  [2];
    int   m_ptr   [2];
    int   last_acc [2][NW];
    int   cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset(input int d);
        m_valid[d] = 1'b0;
        m_warp[d]  = 0;
        m_ptr[d]   = 0;
        for (int i = 0; i < NW; i++) last_acc[d][i] = -1000;
    endtask

    task automatic model_step(input int d);
        stat_t       s;
        logic [15:0] bl;
        bit          acc, found;
        int          sel, idx;
        if (!reset) begin
            model_reset(d);
            s = '0;
            s.empty = (req == 16'h0);
            exp_stat[d].push_back(s);
            return;
        end
        for (int i = 0; i < NW; i++) bl[i] = ((cyc - last_acc[d][i]) <= cd[d]);
        s.valid   = m_valid[d];
        s.warp    = 4'(m_warp[d]);
        s.oh      = m_valid[d] ? (16'h1 << m_warp[d]) : 16'h0;
        s.blocked = bl;
        s.empty   = !m_valid[d] && ((req & ~bl) == 16'h0);
        exp_stat[d].push_back(s);
        acc = m_valid[d] && ready && !flush;
        if (acc) exp_xfer[d].push_back(m_warp[d]);
        if (flush) begin
            m_valid[d] = 1'b0;
            for (int i = 0; i < NW; i++) last_acc[d][i] = -1000;
        end else if (!(m_valid[d] && !ready)) begin
            found = 0;
            sel   = 0;
            for (int k = 0; k < NW; k++) begin
                idx = (m_ptr[d] + k) % NW;
                if (!found && req[idx] && !bl[idx] && !(acc && m_warp[d] == idx)) begin
                    found = 1;
                    sel   = idx;
                end
            end
            if (acc) begin
                m_ptr[d] = (m_warp[d] + 1) % NW;
                last_acc[d][m_warp[d]] = cyc;
            end
            m_valid[d] = found;
            if (found) m_warp[d] = sel;
        end
    endtask

    // Inputs change on the falling edge; the model predicts that cycle's outputs.
    task automatic drive(input logic rst, input logic [15:0] r, input logic fl, input logic rd);
        @(negedge clk);
        reset = rst;
        req   = r;
        flush = fl;
        ready = rd;
        model_step(0);
        model_step(1);
        cyc++;
    endtask

    // Monitor: samples mid-cycle, pops per-cycle status and, on a real transfer, the expected warp.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            for (int d = 0; d < 2; d++) begin
                logic        v;
                logic [3:0]  w;
                logic [15:0] oh, bl;
                logic        e;
                stat_t       s;
                v  = (d == 0) ? if0.issue_valid   : if1.issue_valid;
                w  = (d == 0) ? if0.issue_warp    : if1.issue_warp;
                oh = (d == 0) ? if0.issue_warp_oh : if1.issue_warp_oh;
                bl = (d == 0) ? blk0 : blk1;
                e  = (d == 0) ? emp0 : emp1;
                if (exp_stat[d].size() > 0) begin
                    s = exp_stat[d].pop_front();
                    check($sformatf("d%0d issue_valid", d), 32'(v), 32'(s.valid));
                    check($sformatf("d%0d issue_warp_oh", d), 32'(oh), 32'(s.oh));
                    check($sformatf("d%0d blocked", d), 32'(bl), 32'(s.blocked));
                    check($sformatf("d%0d empty", d), 32'(e), 32'(s.empty));
                    if (s.valid) check($sformatf("d%0d issue_warp", d), 32'(w), 32'(s.warp));
                end
                if (v && ready && !flush && reset) begin
                    check($sformatf("d%0d xfer_expected", d), 32'(exp_xfer[d].size() != 0), 32'd1);
                    if (exp_xfer[d].size() != 0) begin
                        check($sformatf("d%0d xfer_warp", d), 32'(w), 32'(exp_xfer[d].pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        logic [15:0] rq;
        reset = 1'b0;
        req   = 16'hFFFF;
        flush = 1'b0;
        ready = 1'b1;
        model_reset(0);
        model_reset(1);

        // All warps requesting from reset release: 0..15 then wrap.
        repeat (3)  drive(1'b0, 16'hFFFF, 1'b0, 1'b1);
        repeat (20) drive(1'b1, 16'hFFFF, 1'b0, 1'b1);
        // Lone warp 3: cooldown spacing.
        repeat (16) drive(1'b1, 16'h0008, 1'b0, 1'b1);
        // Warps 0 and 15: alternation across the wrap.
        repeat (10) drive(1'b1, 16'h8001, 1'b0, 1'b1);
        repeat (6)  drive(1'b1, 16'h0000, 1'b0, 1'b1);
        // Stall on warp 5 while its request drops, then release.
        drive(1'b1, 16'h0020, 1'b0, 1'b0);
        repeat (5)  drive(1'b1, 16'h0040, 1'b0, 1'b0);
        repeat (3)  drive(1'b1, 16'h0040, 1'b0, 1'b1);
        repeat (6)  drive(1'b1, 16'h0000, 1'b0, 1'b1);
        // Flush over a live handshake with cooldowns running.
        repeat (4)  drive(1'b1, 16'h0006, 1'b0, 1'b1);
        drive(1'b1, 16'h0006, 1'b1, 1'b1);
        repeat (4)  drive(1'b1, 16'h0006, 1'b0, 1'b1);
        // Asynchronous reset mid-stream, then a lone warp 4.
        repeat (4)  drive(1'b1, 16'h0F0F, 1'b0, 1'b1);
        drive(1'b1, 16'h0F0F, 1'b0, 1'b0);
        drive(1'b0, 16'h0F0F, 1'b0, 1'b0);
        drive(1'b0, 16'h0010, 1'b0, 1'b1);
        repeat (4)  drive(1'b1, 16'h0010, 1'b0, 1'b1);

        // Randomized traffic with backpressure, flushes and occasional resets.
        rq = 16'hFFFF;
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0: rq = 16'($urandom);
                    1: rq = 16'($urandom) & 16'($urandom) & 16'($urandom);
                    2: rq = 16'hFFFF;
                    default: rq = 16'h1 << $urandom_range(0, 15);
                endcase
            end
            drive($urandom_range(0, 99) != 0, rq, $urandom_range(0, 31) == 0,
                  $urandom_range(0, 3) != 0);
        end
        repeat (3) drive(1'b1, 16'h0000, 1'b0, 1'b1);

        @(negedge clk);
        #4;
        check("d0 xfer_drained", 32'(exp_xfer[0].size()), 32'd0);
        check("d1 xfer_drained", 32'(exp_xfer[1].size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
